// File: rtl/seq_divider_16b_pkg.sv
// seq_divider_16b_pkg: shared state encodings, data width and step-count terminal value for the divider
package seq_divider_16b_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10, DONE = 2'b11} state_t;
  localparam int WIDTH = 16;
  localparam logic [3:0] LAST_STEP = 4'd15;
endpackage

// File: rtl/seq_divider_16b_if.sv
// seq_divider_16b_if: divider handshake bus; master drives start/A/B/sign, slave returns busy/done/Quot/Rem/DivZero/Ofl
interface seq_divider_16b_if;
  import seq_divider_16b_pkg::*;
  logic start;
  logic sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic busy;
  logic done;
  logic [WIDTH-1:0] Quot;
  logic [WIDTH-1:0] Rem;
  logic DivZero;
  logic Ofl;
  modport master (output start, sign, A, B, input busy, done, Quot, Rem, DivZero, Ofl);
  modport slave (input start, sign, A, B, output busy, done, Quot, Rem, DivZero, Ofl);
endinterface

// File: rtl/cla_16b.sv
// cla_16b: 16-bit carry-lookahead adder with 4-bit groups, ports a/b/c_in in, sum/c_out out
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [15:0] g, p;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;
  logic [16:0] c;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      gp[i] = &p[4*i +: 4];
      gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (&p[4*i+2 +: 2] & g[4*i+1]) | (&p[4*i+1 +: 3] & g[4*i]);
    end
    gc[0] = c_in;
    for (int i = 0; i < 4; i++) gc[i+1] = gg[i] | (gp[i] & gc[i]);
    c[0] = gc[0];
    for (int i = 1; i < 17; i++) c[i] = (i % 4 == 0) ? gc[i/4] : (g[i-1] | (p[i-1] & c[i-1]));
  end
  assign sum = p ^ c[15:0];
  assign c_out = c[16];
endmodule

// File: rtl/flop.sv
// flop: W-bit register, ports clk/rst (sync active-high, clears to 0), d in, q out
module flop #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= rst ? '0 : d;
endmodule

// File: rtl/negate_16b.sv
// negate_16b: two's-complement negate built on cla_16b, port x in, y = -x out
module negate_16b (
  input  logic [15:0] x,
  output logic [15:0] y
);
  logic unused_co;
  cla_16b u_cla (.a(~x), .b(16'h0000), .c_in(1'b1), .sum(y), .c_out(unused_co));
endmodule

// File: rtl/seq_divider_16b.sv
// seq_divider_16b: restoring 16-bit signed/unsigned divider, ports clk/rst plus slave bus (start,A,B,sign -> busy,done,Quot,Rem,DivZero,Ofl)
module seq_divider_16b (
  input logic              clk,
  input logic              rst,
  seq_divider_16b_if.slave bus
);
  import seq_divider_16b_pkg::*;
  state_t state_q, state_d;
  logic [1:0] state_raw;
  logic [3:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, qr_q, qr_d, bm_q, bm_d, quot_q, quot_d, rem_q, rem_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, oflp_q, oflp_d, dz_q, dz_d, ofl_q, ofl_d;
  logic [WIDTH-1:0] neg_a, neg_b, low, diff;
  logic co, take, idle;
  assign state_q = state_t'(state_raw);
  assign idle = state_q == IDLE;
  negate_16b u_neg_a (.x(idle ? bus.A : qr_q), .y(neg_a));
  negate_16b u_neg_b (.x(idle ? bus.B : r_q), .y(neg_b));
  assign low = {r_q[WIDTH-2:0], qr_q[WIDTH-1]};
  cla_16b u_sub (.a(low), .b(~bm_q), .c_in(1'b1), .sum(diff), .c_out(co));
  assign take = r_q[WIDTH-1] | co;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    qr_d = qr_q;
    bm_d = bm_q;
    quot_d = quot_q;
    rem_d = rem_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    oflp_d = oflp_q;
    dz_d = dz_q;
    ofl_d = ofl_q;
    if (idle && bus.start) begin
      qr_d = (bus.sign && bus.A[WIDTH-1]) ? neg_a : bus.A;
      bm_d = (bus.sign && bus.B[WIDTH-1]) ? neg_b : bus.B;
      qneg_d = bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      rneg_d = bus.sign & bus.A[WIDTH-1];
      oflp_d = bus.sign & (bus.A == 16'h8000) & (bus.B == 16'hFFFF);
      r_d = '0;
      cnt_d = '0;
      ofl_d = 1'b0;
      dz_d = bus.B == '0;
      state_d = (bus.B == '0) ? DONE : CALC;
      quot_d = (bus.B == '0) ? 16'hFFFF : quot_q;
      rem_d = (bus.B == '0) ? bus.A : rem_q;
    end else if (state_q == CALC) begin
      r_d = take ? diff : low;
      qr_d = {qr_q[WIDTH-2:0], take};
      cnt_d = cnt_q + 4'd1;
      state_d = (cnt_q == LAST_STEP) ? FIX : CALC;
    end else if (state_q == FIX) begin
      quot_d = qneg_q ? neg_a : qr_q;
      rem_d = rneg_q ? neg_b : r_q;
      ofl_d = oflp_q;
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  flop #(.W(2))     u_state (.clk(clk), .rst(rst), .d(state_d), .q(state_raw));
  flop #(.W(4))     u_cnt   (.clk(clk), .rst(rst), .d(cnt_d),   .q(cnt_q));
  flop #(.W(WIDTH)) u_r     (.clk(clk), .rst(rst), .d(r_d),     .q(r_q));
  flop #(.W(WIDTH)) u_qr    (.clk(clk), .rst(rst), .d(qr_d),    .q(qr_q));
  flop #(.W(WIDTH)) u_bm    (.clk(clk), .rst(rst), .d(bm_d),    .q(bm_q));
  flop #(.W(WIDTH)) u_quot  (.clk(clk), .rst(rst), .d(quot_d),  .q(quot_q));
  flop #(.W(WIDTH)) u_rem   (.clk(clk), .rst(rst), .d(rem_d),   .q(rem_q));
  flop #(.W(1))     u_qneg  (.clk(clk), .rst(rst), .d(qneg_d),  .q(qneg_q));
  flop #(.W(1))     u_rneg  (.clk(clk), .rst(rst), .d(rneg_d),  .q(rneg_q));
  flop #(.W(1))     u_oflp  (.clk(clk), .rst(rst), .d(oflp_d),  .q(oflp_q));
  flop #(.W(1))     u_dz    (.clk(clk), .rst(rst), .d(dz_d),    .q(dz_q));
  flop #(.W(1))     u_ofl   (.clk(clk), .rst(rst), .d(ofl_d),   .q(ofl_q));
  assign bus.busy = (state_q == CALC) || (state_q == FIX);
  assign bus.done = state_q == DONE;
  assign bus.Quot = quot_q;
  assign bus.Rem = rem_q;
  assign bus.DivZero = dz_q;
  assign bus.Ofl = ofl_q;
endmodule

// File: tb/tb_seq_divider_16b.sv
// tb_seq_divider_16b: directed vector table plus handshake/reset sequences for seq_divider_16b
module tb_seq_divider_16b;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] prev_q = 16'h0000;
  int lat, bc, dones;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        of;
  } vec_t;
  vec_t v[11];
  seq_divider_16b_if bus();
  seq_divider_16b dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    bus.A = a;
    bus.B = b;
    bus.sign = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = 16'hDEAD;
    bus.B = 16'hBEEF;
    bus.sign = ~s;
  endtask
  task automatic wait_done(output int l, output int n);
    l = 0;
    n = 0;
    while (!bus.done && l < 40) begin
      if (bus.busy) n++;
      if (l == 5) chk("hold_quot", {16'h0, bus.Quot}, {16'h0, prev_q});
      @(posedge clk);
      #1;
      l++;
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.sign = 1'b0;
    v[0]  = '{16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 1'b0};
    v[1]  = '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0};
    v[2]  = '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0};
    v[3]  = '{16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0};
    v[4]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1};
    v[5]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0};
    v[6]  = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    v[7]  = '{16'h0003, 16'hFFFF, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b0};
    v[8]  = '{16'hABCD, 16'h0000, 1'b0, 16'hFFFF, 16'hABCD, 1'b1, 1'b0};
    v[9]  = '{16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 1'b0};
    v[10] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_quot", {16'h0, bus.Quot}, 32'h0);
    chk("rst_rem", {16'h0, bus.Rem}, 32'h0);
    chk("rst_dz", {31'h0, bus.DivZero}, 32'h0);
    chk("rst_ofl", {31'h0, bus.Ofl}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      start_op(v[i].a, v[i].b, v[i].s);
      wait_done(lat, bc);
      chk($sformatf("v%0d_latency", i), lat, v[i].dz ? 32'd0 : 32'd17);
      chk($sformatf("v%0d_busy_cycles", i), bc, v[i].dz ? 32'd0 : 32'd17);
      chk($sformatf("v%0d_quot", i), {16'h0, bus.Quot}, {16'h0, v[i].q});
      chk($sformatf("v%0d_rem", i), {16'h0, bus.Rem}, {16'h0, v[i].r});
      chk($sformatf("v%0d_divzero", i), {31'h0, bus.DivZero}, {31'h0, v[i].dz});
      chk($sformatf("v%0d_ofl", i), {31'h0, bus.Ofl}, {31'h0, v[i].of});
      prev_q = v[i].q;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {31'h0, bus.done}, 32'h0);
      chk($sformatf("v%0d_quot_held", i), {16'h0, bus.Quot}, {16'h0, v[i].q});
    end
    start_op(16'd100, 16'd7, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus.A = 16'd1000;
    bus.B = 16'd3;
    bus.sign = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, bc);
    chk("repulse_latency", lat, 32'd12);
    chk("repulse_quot", {16'h0, bus.Quot}, 32'd14);
    chk("repulse_rem", {16'h0, bus.Rem}, 32'd2);
    prev_q = 16'd14;
    @(posedge clk);
    #1;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    chk("abort_quot", {16'h0, bus.Quot}, 32'h0);
    chk("abort_rem", {16'h0, bus.Rem}, 32'h0);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    prev_q = 16'h0000;
    start_op(16'd100, 16'd7, 1'b0);
    wait_done(lat, bc);
    chk("fresh_latency", lat, 32'd17);
    chk("fresh_quot", {16'h0, bus.Quot}, 32'd14);
    chk("fresh_rem", {16'h0, bus.Rem}, 32'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_divider_16b.md
Name: seq_divider_16b

Overview:
- Multi-cycle 16-bit integer divider. It is the inverse-direction companion to the combinational add/logic unit.
- Uses one shift-subtract step per cycle (restoring algorithm). Supports signed and unsigned operands.
- Sits beside the ALU in the execute stage and is driven by a start/done handshake. The pipeline stalls while busy is high.

Parameters:
- WIDTH, 16, operand/result width. Only 16 is supported; the step counter is sized by it.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  16  dividend
- B  input  16  divisor
- sign  input  1  1 = two's-complement operands, 0 = unsigned
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse when results become valid
- Quot  output  16  quotient, held until next accepted start
- Rem  output  16  remainder, held until next accepted start
- DivZero  output  1  B was zero for the current result
- Ofl  output  1  signed overflow (-32768 / -1)

Behaviour:
- Reset: state=IDLE. busy, done, DivZero, Ofl = 0. Quot, Rem = 16'h0000. Step counter = 0. A reset mid-operation aborts immediately with the same values; no partial result is ever exposed.
- States:
  - IDLE -> CALC on start with B!=0.
  - IDLE -> DONE on start with B==0.
  - CALC -> FIX after 16 steps.
  - FIX -> DONE.
  - DONE -> IDLE unconditionally.
- Start accepted in IDLE at edge k:
  - Latch operand magnitudes: if sign and operand[15], use the negated operand, else the raw operand.
  - Latch the result-sign bits: qneg = sign & (A[15]^B[15]); rneg = sign & A[15].
  - Clear the partial remainder. Step counter = 0. Clear DivZero, Ofl.
- CALC, each cycle:
  - Form the trial value {R, Qreg[15]} (17 bits).
  - Subtract |B| using a 16-bit CLA. The trial succeeds if the shifted-out R MSB is 1 or the CLA carry-out is 1.
  - On success: R = difference, shift in quotient bit 1. Otherwise R = shifted value, shift in 0.
  - Exactly 16 CALC cycles (counter 0..15).
- FIX:
  - Quot = qneg ? -Qmag : Qmag. Rem = rneg ? -Rmag : Rmag.
  - Ofl = sign & (A==16'h8000) & (B==16'hFFFF). Quot wraps to 16'h8000 in that case.
  - Unsigned divisions never set Ofl.
- DONE: done=1 for exactly one cycle. busy=0.
- Latency:
  - Normal division: done high in cycle k+18 (16 CALC cycles, 1 FIX, then DONE).
  - Divide by zero: done high in cycle k+1 with Quot=16'hFFFF, Rem=A (raw), DivZero=1, Ofl=0. Identical for signed and unsigned.
- Handshake rules:
  - start while busy or in DONE is ignored; operands are not re-sampled.
  - start in the cycle after done (IDLE) is accepted.
  - A, B and sign only need to be valid in the cycle start is accepted.
- Output holding: Quot, Rem, DivZero and Ofl keep their last values through IDLE. They change only at the FIX edge or the divide-by-zero DONE edge of a later operation.
- Remainder rules:
  - The remainder takes the sign of the dividend (truncating division).
  - |Rem| < |B|, except when B==0.

Decomposition:
- Shared include file holds:
  - the state encodings (IDLE=2'b00, CALC=2'b01, FIX=2'b10, DONE=2'b11)
  - a WIDTH constant
  - the step-count terminal value (15)
- Sub-modules:
  - Reuse existing cla_16b for the trial subtract: b = ~|B|, c_in = 1.
  - One natural new sub-module, negate_16b (two's-complement negate via cla_16b with a=~x, b=0, c_in=1). It is instantiated for operand and result sign fix-up.
- State registers are built from the existing flop primitive with synchronous reset.

Test Plan:
- Unsigned 100/7: sign=0, A=16'd100, B=16'd7, start pulse -> busy for 17 cycles; done at k+18; Quot=16'd14, Rem=16'd2, DivZero=0, Ofl=0.
- Signed -7/2: A=16'hFFF9, B=16'h0002, sign=1 -> Quot=16'hFFFD (-3), Rem=16'hFFFF (-1). Also 7/-2 -> Quot=16'hFFFD, Rem=16'h0001.
- Divide by zero: A=16'h1234, B=0, sign=1 -> done at k+1, busy never high; Quot=16'hFFFF, Rem=16'h1234, DivZero=1.
- Overflow: A=16'h8000, B=16'hFFFF, sign=1 -> Quot=16'h8000, Rem=0, Ofl=1. Same operands with sign=0 -> Quot=0, Rem=16'h8000, Ofl=0.
- Full range, unsigned: 16'hFFFF/16'h0001 -> Quot=16'hFFFF, Rem=0.
- Edge case, unsigned: 16'h0003/16'hFFFF -> Quot=0, Rem=3.
- Control:
  - start re-pulsed at k+5 with new operands -> ignored; the original result is produced at k+18.
  - rst asserted at k+9 -> next cycle: IDLE, busy=0, Quot=Rem=0. No done pulse follows.
  - A fresh start afterwards completes normally.
